scnn_psum_acc_controller: RTL and testbench
===========================================

// Module: scnn_psum_acc_controller
// PURPOSE
//  Downstream consumer of the shape-info compiler: per layer, sequences partial-sum accumulation in the GLB psum bank.
//  Latches psum_depth / psum_acc_times_bound at layer start and generates GLB psum write addresses plus first-pass/accumulate flags.
//  After the last pass, drains the bank to the ofmap path over a valid/ready handshake, then pulses psum_acc_done to the TOP layer FSM.
// PARAMETERS
//  DATA_W  16  psum word width
//  ADDR_W  6   GLB psum address width (covers psum_depth up to 63)
//  ACC_W   8   accumulation pass counter width (matches psum_acc_times_bound)
// PORTS
//  clock                 in   1       system clock
//  reset                 in   1       synchronous, active-high
//  layer_start           in   1       one-cycle pulse: begin layer, latch bounds
//  psum_depth            in   6       words per pass, from shape-info compiler
//  psum_acc_times_bound  in   8       passes per layer, from shape-info compiler
//  pe_psum_valid         in   1       PE array presents one psum word
//  pe_psum_data          in   DATA_W  psum word from PE array
//  pe_psum_ready         out  1       controller accepts word (high only in ACCUM)
//  glb_psum_wr_en        out  1       GLB psum write strobe
//  glb_psum_wr_addr      out  ADDR_W  GLB psum write address
//  glb_psum_wr_data      out  DATA_W  registered psum word
//  glb_psum_acc          out  1       0: overwrite (first pass), 1: read-add-write
//  glb_psum_rd_en        out  1       GLB psum read strobe (drain)
//  glb_psum_rd_addr      out  ADDR_W  GLB psum read address
//  glb_psum_rd_data      in   DATA_W  GLB read data, valid 1 cycle after rd_en
//  ofmap_valid           out  1       drained word valid
//  ofmap_data            out  DATA_W  drained word (held until accepted)
//  ofmap_ready           in   1       downstream accepts drained word
//  busy                  out  1       high in any state except IDLE
//  psum_acc_done         out  1       one-cycle pulse at end of layer
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; addr/pass counters 0; latched bounds 0.
//  Latch: on layer_start in IDLE, depth_q = (psum_depth==0 ? 1 : psum_depth); bound_q = (bound==0 ? 1 : bound).
//  States: IDLE -> ACCUM (layer_start) -> DRAIN_RD -> DRAIN_WAIT -> DRAIN_RD ... -> DONE -> IDLE.
//  ACCUM: pe_psum_ready=1; handshake = valid & ready. On accepted word at cycle N:
//   - at N+1: wr_en=1, wr_addr=addr_cnt, wr_data=data, acc=(pass_cnt!=0).
//   - addr_cnt++; when addr_cnt==depth_q-1 it wraps to 0 and pass_cnt++.
//   - wrap with pass_cnt==bound_q-1: next state DRAIN_RD; pass_cnt, addr_cnt cleared.
//  No valid: counters and outputs hold; wr_en=0 that cycle (no bubble writes).
//  DRAIN_RD: pe_psum_ready=0; rd_en=1 for one cycle, rd_addr=addr_cnt; go to DRAIN_WAIT.
//  DRAIN_WAIT: first cycle captures rd_data into ofmap_data; ofmap_valid=1, held stable until ofmap_ready.
//   On ofmap_valid & ofmap_ready: addr_cnt++; if last addr (depth_q-1) -> DONE, else -> DRAIN_RD.
//   Throughput: at most 1 drained word per 2 cycles.
//  DONE: psum_acc_done=1 for exactly one cycle; counters cleared; -> IDLE.
//  Boundaries:
//   - layer_start while busy: ignored.
//   - Final write (last word of last pass) issues at N+1, same cycle as first DRAIN_RD; GLB must support write-before-read ordering.
//   - psum_depth/bound input changes mid-layer: no effect (latched values used).
//   - pe_psum_valid outside ACCUM: not accepted (ready=0); PE must hold.
//   - reset mid-operation: immediate return to IDLE, all outputs 0 next cycle, no done pulse.
// STRUCTURE
//  Shared package scnn_pkg: FSM state encoding (IDLE, ACCUM, DRAIN_RD, DRAIN_WAIT, DONE), DATA_W/ADDR_W/ACC_W defaults.
//  Sub-module scnn_wrap_counter (load/clear/inc, programmable bound, wrap pulse): used for addr_cnt and pass_cnt.
// TESTING
//  T1 depth=32, bound=12, continuous valid -> 384 writes; acc=0 for the first 32, then 1; 32 drains; done after the last ofmap accept.
//  T2 depth=4, bound=1 -> 4 writes, all acc=0; drain addrs 0,1,2,3; one done pulse; busy low the cycle after done.
//  T3 depth=0, bound=0 -> treated as 1/1: one write at addr 0, one drain, done.
//  T4 random valid gaps and ofmap_ready stalls -> no dropped or duplicate writes; ofmap_data stable while stalled; address order matches the golden model.
//  T5 layer_start pulsed during ACCUM and DRAIN -> ignored; counts unchanged.
//  T6 reset asserted mid-ACCUM (pass 3 of 12) -> next cycle IDLE, outputs 0; a new layer_start completes a full layer correctly.

Source files
------------

// File: rtl/scnn_pkg.sv
// Shared definitions for the SCNN psum accumulation path.
// Holds the controller FSM encoding and the default datapath widths.
package scnn_pkg;

    localparam int SCNN_DATA_W = 16;
    localparam int SCNN_ADDR_W = 6;
    localparam int SCNN_ACC_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCUM      = 3'd1,
        ST_DRAIN_RD   = 3'd2,
        ST_DRAIN_WAIT = 3'd3,
        ST_DONE       = 3'd4
    } psum_state_t;

endpackage

// File: rtl/scnn_wrap_counter.sv
// Up-counter with a programmable terminal value.
// Wraps to zero after 'last'; 'wrap' flags the increment that causes the wrap.
module scnn_wrap_counter #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == last);

    // Counter register: clear has priority over increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (inc) begin
            count <= wrap ? {W{1'b0}} : count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/scnn_psum_acc_controller.sv
// Per-layer psum accumulation sequencer: streams PE psums into the GLB bank
// pass by pass, then drains the bank to the ofmap path and signals completion.
module scnn_psum_acc_controller
    import scnn_pkg::*;
#(
    parameter int DATA_W = SCNN_DATA_W,
    parameter int ADDR_W = SCNN_ADDR_W,
    parameter int ACC_W  = SCNN_ACC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              layer_start,
    input  logic [ADDR_W-1:0] psum_depth,
    input  logic [ACC_W-1:0]  psum_acc_times_bound,
    input  logic              pe_psum_valid,
    input  logic [DATA_W-1:0] pe_psum_data,
    output logic              pe_psum_ready,
    output logic              glb_psum_wr_en,
    output logic [ADDR_W-1:0] glb_psum_wr_addr,
    output logic [DATA_W-1:0] glb_psum_wr_data,
    output logic              glb_psum_acc,
    output logic              glb_psum_rd_en,
    output logic [ADDR_W-1:0] glb_psum_rd_addr,
    input  logic [DATA_W-1:0] glb_psum_rd_data,
    output logic              ofmap_valid,
    output logic [DATA_W-1:0] ofmap_data,
    input  logic              ofmap_ready,
    output logic              busy,
    output logic              psum_acc_done
);

    psum_state_t       state;
    psum_state_t       state_next;
    logic [ADDR_W-1:0] depth_q;
    logic [ACC_W-1:0]  bound_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ACC_W-1:0]  pass_cnt;
    logic [ADDR_W-1:0] addr_last;
    logic [ACC_W-1:0]  pass_last;
    logic              addr_wrap;
    logic              pass_wrap;
    logic              accept;
    logic              drain_take;
    logic              start;
    logic              cnt_clear;

    assign accept     = pe_psum_valid && pe_psum_ready;
    assign drain_take = (state == ST_DRAIN_WAIT) && ofmap_valid && ofmap_ready;
    assign start      = (state == ST_IDLE) && layer_start;
    assign cnt_clear  = start || (state == ST_DONE);
    assign addr_last  = depth_q - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pass_last  = bound_q - {{(ACC_W-1){1'b0}}, 1'b1};

    // The address counter serves both the write passes and the drain sweep.
    scnn_wrap_counter #(.W(ADDR_W)) u_addr_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (accept || drain_take),
        .last  (addr_last),
        .count (addr_cnt),
        .wrap  (addr_wrap)
    );

    scnn_wrap_counter #(.W(ACC_W)) u_pass_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (accept && addr_wrap),
        .last  (pass_last),
        .count (pass_cnt),
        .wrap  (pass_wrap)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; layer_start outside IDLE is ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (layer_start) state_next = ST_ACCUM;
                else             state_next = ST_IDLE;
            end
            ST_ACCUM: begin
                if (accept && addr_wrap && pass_wrap) state_next = ST_DRAIN_RD;
                else                                  state_next = ST_ACCUM;
            end
            ST_DRAIN_RD: state_next = ST_DRAIN_WAIT;
            ST_DRAIN_WAIT: begin
                if (drain_take) state_next = addr_wrap ? ST_DONE : ST_DRAIN_RD;
                else            state_next = ST_DRAIN_WAIT;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        pe_psum_ready    = 1'b0;
        glb_psum_rd_en   = 1'b0;
        glb_psum_rd_addr = {ADDR_W{1'b0}};
        busy             = 1'b1;
        psum_acc_done    = 1'b0;
        case (state)
            ST_IDLE:       busy = 1'b0;
            ST_ACCUM:      pe_psum_ready = 1'b1;
            ST_DRAIN_RD: begin
                glb_psum_rd_en   = 1'b1;
                glb_psum_rd_addr = addr_cnt;
            end
            ST_DRAIN_WAIT: busy = 1'b1;
            ST_DONE:       psum_acc_done = 1'b1;
            default:       busy = 1'b0;
        endcase
    end

    // Zero bounds are promoted to one so a degenerate layer still completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= {ADDR_W{1'b0}};
            bound_q <= {ACC_W{1'b0}};
        end else if (start) begin
            depth_q <= (psum_depth == {ADDR_W{1'b0}}) ? {{(ADDR_W-1){1'b0}}, 1'b1} : psum_depth;
            bound_q <= (psum_acc_times_bound == {ACC_W{1'b0}}) ?
                       {{(ACC_W-1){1'b0}}, 1'b1} : psum_acc_times_bound;
        end
    end

    // GLB write port: one registered write per accepted word, fields held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            glb_psum_wr_en   <= 1'b0;
            glb_psum_wr_addr <= {ADDR_W{1'b0}};
            glb_psum_wr_data <= {DATA_W{1'b0}};
            glb_psum_acc     <= 1'b0;
        end else begin
            glb_psum_wr_en <= accept;
            if (accept) begin
                glb_psum_wr_addr <= addr_cnt;
                glb_psum_wr_data <= pe_psum_data;
                glb_psum_acc     <= (pass_cnt != {ACC_W{1'b0}});
            end
        end
    end

    // Drain output: capture GLB read data once per word and hold it until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            ofmap_valid <= 1'b0;
            ofmap_data  <= {DATA_W{1'b0}};
        end else if (drain_take) begin
            ofmap_valid <= 1'b0;
        end else if ((state == ST_DRAIN_WAIT) && !ofmap_valid) begin
            ofmap_valid <= 1'b1;
            ofmap_data  <= glb_psum_rd_data;
        end
    end

endmodule

// File: tb/tb_scnn_psum_acc_controller.sv
// Testbench for scnn_psum_acc_controller: GLB memory model plus a per-layer
// reference model of expected writes, drain order/values and completion.
module tb_scnn_psum_acc_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        layer_start;
    logic [5:0]  psum_depth;
    logic [7:0]  psum_acc_times_bound;
    logic        pe_psum_valid;
    logic [15:0] pe_psum_data;
    logic        pe_psum_ready;
    logic        glb_psum_wr_en;
    logic [5:0]  glb_psum_wr_addr;
    logic [15:0] glb_psum_wr_data;
    logic        glb_psum_acc;
    logic        glb_psum_rd_en;
    logic [5:0]  glb_psum_rd_addr;
    logic [15:0] glb_psum_rd_data;
    logic        ofmap_valid;
    logic [15:0] ofmap_data;
    logic        ofmap_ready;
    logic        busy;
    logic        psum_acc_done;

    scnn_psum_acc_controller dut (
        .clock                (clock),
        .reset                (reset),
        .layer_start          (layer_start),
        .psum_depth           (psum_depth),
        .psum_acc_times_bound (psum_acc_times_bound),
        .pe_psum_valid        (pe_psum_valid),
        .pe_psum_data         (pe_psum_data),
        .pe_psum_ready        (pe_psum_ready),
        .glb_psum_wr_en       (glb_psum_wr_en),
        .glb_psum_wr_addr     (glb_psum_wr_addr),
        .glb_psum_wr_data     (glb_psum_wr_data),
        .glb_psum_acc         (glb_psum_acc),
        .glb_psum_rd_en       (glb_psum_rd_en),
        .glb_psum_rd_addr     (glb_psum_rd_addr),
        .glb_psum_rd_data     (glb_psum_rd_data),
        .ofmap_valid          (ofmap_valid),
        .ofmap_data           (ofmap_data),
        .ofmap_ready          (ofmap_ready),
        .busy                 (busy),
        .psum_acc_done        (psum_acc_done)
    );

    always #5 clock = ~clock;

    // GLB psum bank: write-before-read when both hit the same address.
    logic [15:0] mem [0:63];
    always @(posedge clock) begin
        if (glb_psum_wr_en)
            mem[glb_psum_wr_addr] <= glb_psum_acc ? mem[glb_psum_wr_addr] + glb_psum_wr_data
                                                  : glb_psum_wr_data;
        if (glb_psum_rd_en) begin
            if (glb_psum_wr_en && glb_psum_wr_addr == glb_psum_rd_addr)
                glb_psum_rd_data <= glb_psum_acc ? mem[glb_psum_rd_addr] + glb_psum_wr_data
                                                 : glb_psum_wr_data;
            else
                glb_psum_rd_data <= mem[glb_psum_rd_addr];
        end
    end

    typedef struct {
        logic [5:0]  addr;
        logic        acc;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int depth_in;
        int bound_in;
        int vpct;
        int rpct;
        bit inject;
        int exp_writes;
        int exp_drains;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state for the current layer.
    int          d, b, total;
    int          acc_count, wr_count, rd_count, drain_count, done_count;
    bit          in_layer, pe_taken, of_hold, prev_done;
    logic [15:0] of_held;
    logic [15:0] ref_sum [0:63];
    wr_t         exp_wr [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        wr_t e;
        if (glb_psum_wr_en) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'(glb_psum_wr_en), 32'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(glb_psum_wr_addr), 32'(e.addr));
                chk("wr_acc",  32'(glb_psum_acc),     32'(e.acc));
                chk("wr_data", 32'(glb_psum_wr_data), 32'(e.data));
            end
            wr_count++;
        end
        if (in_layer) chk("pe_ready", 32'(pe_psum_ready), 32'(acc_count < total));
        if (pe_psum_valid && pe_psum_ready) begin
            e.addr = 6'(acc_count % d);
            e.acc  = (acc_count >= d);
            e.data = pe_psum_data;
            exp_wr.push_back(e);
            ref_sum[e.addr] = ref_sum[e.addr] + pe_psum_data;
            acc_count++;
            pe_taken = 1'b1;
        end
        if (glb_psum_rd_en) begin
            chk("rd_addr", 32'(glb_psum_rd_addr), 32'(rd_count));
            rd_count++;
        end
        if (ofmap_valid) begin
            if (of_hold) chk("ofmap_stable", 32'(ofmap_data), 32'(of_held));
            if (ofmap_ready) begin
                chk("drain_data", 32'(ofmap_data), 32'(ref_sum[drain_count % 64]));
                drain_count++;
                of_hold = 1'b0;
            end else begin
                of_hold = 1'b1;
                of_held = ofmap_data;
            end
        end else begin
            of_hold = 1'b0;
        end
        if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
        prev_done = psum_acc_done;
        if (psum_acc_done) begin
            done_count++;
            chk("done_drains", 32'(drain_count), 32'(d));
            chk("done_writes", 32'(wr_count), 32'(total));
        end
    endtask

    // Check outputs at mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pe_ready"}, 32'(pe_psum_ready),    32'd0);
        chk({tag, "_wr_en"},    32'(glb_psum_wr_en),   32'd0);
        chk({tag, "_wr_addr"},  32'(glb_psum_wr_addr), 32'd0);
        chk({tag, "_wr_data"},  32'(glb_psum_wr_data), 32'd0);
        chk({tag, "_acc"},      32'(glb_psum_acc),     32'd0);
        chk({tag, "_rd_en"},    32'(glb_psum_rd_en),   32'd0);
        chk({tag, "_rd_addr"},  32'(glb_psum_rd_addr), 32'd0);
        chk({tag, "_of_valid"}, 32'(ofmap_valid),      32'd0);
        chk({tag, "_of_data"},  32'(ofmap_data),       32'd0);
        chk({tag, "_busy"},     32'(busy),             32'd0);
        chk({tag, "_done"},     32'(psum_acc_done),    32'd0);
    endtask

    task automatic run_layer(input int depth_in, input int bound_in, input int vpct, input int rpct,
                             input bit inject, input int rst_after, input int exp_w, input int exp_d,
                             output bit aborted);
        int cyc;
        d = (depth_in == 0) ? 1 : depth_in;
        b = (bound_in == 0) ? 1 : bound_in;
        total = d * b;
        acc_count = 0; wr_count = 0; rd_count = 0; drain_count = 0; done_count = 0;
        pe_taken = 1'b0; of_hold = 1'b0; prev_done = 1'b0; aborted = 1'b0;
        exp_wr.delete();
        for (int i = 0; i < 64; i++) ref_sum[i] = 16'd0;
        layer_start = 1'b1;
        psum_depth = 6'(depth_in);
        psum_acc_times_bound = 8'(bound_in);
        step();
        layer_start = 1'b0;
        in_layer = 1'b1;
        for (cyc = 0; cyc < 5000 && done_count == 0; cyc++) begin
            if (rst_after > 0 && acc_count >= rst_after) begin
                aborted = 1'b1;
                break;
            end
            if (!pe_psum_valid || pe_taken) begin
                pe_psum_valid = ($urandom_range(99) < vpct);
                pe_psum_data  = 16'($urandom);
            end
            pe_taken = 1'b0;
            ofmap_ready = ($urandom_range(99) < rpct);
            // Latched bounds must make these mid-layer changes irrelevant.
            psum_depth = 6'($urandom);
            psum_acc_times_bound = 8'($urandom);
            layer_start = inject && busy && ($urandom_range(7) == 0);
            step();
        end
        if (!aborted) begin
            layer_start = 1'b0;
            pe_psum_valid = 1'b0;
            ofmap_ready = 1'b0;
            step();
            step();
            in_layer = 1'b0;
            chk("layer_done_count", 32'(done_count), 32'd1);
            chk("layer_writes",     32'(wr_count),   32'(exp_w));
            chk("layer_accepts",    32'(acc_count),  32'(exp_w));
            chk("layer_drains",     32'(drain_count), 32'(exp_d));
            chk("layer_wr_pending", 32'(exp_wr.size()), 32'd0);
        end
    endtask

    vec_t vecs [0:7];
    bit   ab;
    int   dd, bb;

    initial begin
        vecs[0] = '{32, 12, 100, 100, 1'b0, 384, 32};
        vecs[1] = '{4,  1,  100, 100, 1'b0, 4,   4};
        vecs[2] = '{0,  0,  100, 100, 1'b0, 1,   1};
        vecs[3] = '{7,  5,  60,  40,  1'b0, 35,  7};
        vecs[4] = '{1,  3,  50,  30,  1'b0, 3,   1};
        vecs[5] = '{63, 2,  70,  60,  1'b0, 126, 63};
        vecs[6] = '{5,  4,  80,  50,  1'b1, 20,  5};
        vecs[7] = '{16, 0,  100, 20,  1'b1, 16,  16};

        d = 1; total = 0; in_layer = 1'b0;
        reset = 1'b1; layer_start = 1'b0; psum_depth = 6'd0; psum_acc_times_bound = 8'd0;
        pe_psum_valid = 1'b0; pe_psum_data = 16'd0; ofmap_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_idle("reset");
        @(posedge clock);
        #1;

        for (int v = 0; v < 8; v++)
            run_layer(vecs[v].depth_in, vecs[v].bound_in, vecs[v].vpct, vecs[v].rpct,
                      vecs[v].inject, 0, vecs[v].exp_writes, vecs[v].exp_drains, ab);

        for (int r = 0; r < 3; r++) begin
            dd = $urandom_range(1, 20);
            bb = $urandom_range(1, 4);
            run_layer(dd, bb, 65, 55, 1'b1, 0, dd * bb, dd, ab);
        end

        // Reset in the third pass of a 32x12 layer.
        run_layer(32, 12, 100, 100, 1'b0, 70, 384, 32, ab);
        chk("mid_reset_reached", 32'(ab), 32'd1);
        reset = 1'b1;
        pe_psum_valid = 1'b0;
        layer_start = 1'b0;
        step();
        reset = 1'b0;
        in_layer = 1'b0;
        exp_wr.delete();
        done_count = 0;
        @(negedge clock);
        check_idle("midrst");
        @(posedge clock);
        #1;
        repeat (3) step();
        chk("midrst_no_done", 32'(done_count), 32'd0);
        run_layer(32, 12, 100, 100, 1'b0, 0, 384, 32, ab);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
